// File: rtl/jtframe_rom_arb.sv
// ROM request arbiter: N game slots share one jtframe SDRAM read port.
// Each slot keeps a one-word cache; misses compete under round-robin or fixed priority.
module jtframe_rom_arb #(
    parameter int SLOTS      = 4,
    parameter int AW         = 22,
    parameter int DW         = 32,
    parameter int PRIO_FIXED = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read
);
    localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [GW:0] SLOTS_W = (GW+1)'(SLOTS);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    state_t          state, state_nx;
    logic [SLOTS-1:0] valid, hit, cand;
    logic [AW-1:0]   cached_addr [SLOTS];
    logic [DW-1:0]   cache_data  [SLOTS];
    logic [GW-1:0]   ptr, gnt_idx, win_idx, idx;
    logic [GW:0]     sum;
    logic [AW-1:0]   win_addr;
    logic            win_any, grant, fill;

    always_comb begin
        hit = '0;
        for (int i = 0; i < SLOTS; i++)
            hit[i] = valid[i] && (cached_addr[i] == slot_addr[i*AW +: AW]);
    end

    assign slot_ok = slot_cs & hit & {SLOTS{~downloading}};
    assign cand    = downloading ? '0 : (slot_cs & ~hit);

    // Search order starts at ptr and wraps; with fixed priority it always starts at slot 0.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < SLOTS; k++) begin
            sum = {1'b0, ptr} + (GW+1)'(k);
            if (sum >= SLOTS_W) sum = sum - SLOTS_W;
            idx = (PRIO_FIXED != 0) ? GW'(k) : sum[GW-1:0];
            if (!win_any && cand[idx]) begin
                win_any = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        for (int k = 0; k < SLOTS; k++)
            if (win_idx == GW'(k)) win_addr = slot_addr[k*AW +: AW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (win_any) state_nx = WAIT_ACK;
            WAIT_ACK:  if (sdram_ack) state_nx = data_rdy ? IDLE : WAIT_DATA;
            WAIT_DATA: if (data_rdy) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Handshake: sdram_req stays high with a stable sdram_addr until sdram_ack;
    // data_rdy (in WAIT_DATA, or together with the ack) completes the transfer.
    always_comb begin
        sdram_req = 1'b0;
        grant     = 1'b0;
        fill      = 1'b0;
        case (state)
            IDLE:      grant = win_any;
            WAIT_ACK: begin
                sdram_req = 1'b1;
                fill      = sdram_ack & data_rdy;
            end
            WAIT_DATA: fill = data_rdy;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdram_addr <= '0;
            gnt_idx    <= '0;
            ptr        <= '0;
        end else if (grant) begin
            sdram_addr <= win_addr;
            gnt_idx    <= win_idx;
            if (PRIO_FIXED == 0)
                ptr <= (win_idx == GW'(SLOTS-1)) ? '0 : win_idx + GW'(1);
        end
    end

    // Data is filed under the latched address, so a slot that moved on keeps missing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                cached_addr[i] <= '0;
                cache_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (fill && gnt_idx == GW'(i)) begin
                    cached_addr[i] <= sdram_addr;
                    cache_data[i]  <= data_read;
                end
                if (downloading)                     valid[i] <= 1'b0;
                else if (fill && gnt_idx == GW'(i))  valid[i] <= 1'b1;
            end
        end
    end

    always_comb begin
        slot_dout = '0;
        for (int k = 0; k < SLOTS; k++)
            slot_dout[k*DW +: DW] = cache_data[k];
    end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Bench for jtframe_rom_arb: instance 0 round-robin, instance 1 fixed priority,
// both checked against a transaction-level cache/arbitration model.
module tb_jtframe_rom_arb;
    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int DW    = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                downloading [2];
    logic [SLOTS-1:0]    slot_cs     [2];
    logic [SLOTS*AW-1:0] slot_addr   [2];
    logic [SLOTS-1:0]    slot_ok     [2];
    logic [SLOTS*DW-1:0] slot_dout   [2];
    logic                sdram_req   [2];
    logic [AW-1:0]       sdram_addr  [2];
    logic                sdram_ack   [2];
    logic                data_rdy    [2];
    logic [DW-1:0]       data_read   [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW), .PRIO_FIXED(k)) dut (
            .clk(clk), .rst_n(rst_n), .downloading(downloading[k]),
            .slot_cs(slot_cs[k]), .slot_addr(slot_addr[k]),
            .slot_ok(slot_ok[k]), .slot_dout(slot_dout[k]),
            .sdram_req(sdram_req[k]), .sdram_addr(sdram_addr[k]),
            .sdram_ack(sdram_ack[k]), .data_rdy(data_rdy[k]), .data_read(data_read[k])
        );
    end

    int checks = 0;
    int errors = 0;

    bit            m_valid [2][SLOTS];
    logic [AW-1:0] m_addr  [2][SLOTS];
    logic [DW-1:0] m_data  [2][SLOTS];
    int            m_ptr   [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int k, input int i, input logic [AW-1:0] a);
        slot_addr[k][i*AW +: AW] = a;
    endtask

    function automatic logic [AW-1:0] a_of(input int k, input int i);
        return slot_addr[k][i*AW +: AW];
    endfunction

    function automatic logic [SLOTS-1:0] m_cand(input int k);
        logic [SLOTS-1:0] c;
        for (int i = 0; i < SLOTS; i++)
            c[i] = !downloading[k] && slot_cs[k][i] && !(m_valid[k][i] && m_addr[k][i] == a_of(k, i));
        return c;
    endfunction

    function automatic logic [SLOTS-1:0] m_ok(input int k);
        logic [SLOTS-1:0] o;
        for (int i = 0; i < SLOTS; i++)
            o[i] = !downloading[k] && slot_cs[k][i] && m_valid[k][i] && m_addr[k][i] == a_of(k, i);
        return o;
    endfunction

    // Slot 0 is always first for the fixed-priority instance; instance 0 starts at its pointer.
    function automatic int m_pick(input int k);
        logic [SLOTS-1:0] c;
        int i;
        c = m_cand(k);
        for (int j = 0; j < SLOTS; j++) begin
            i = (k == 1) ? j : (m_ptr[k] + j) % SLOTS;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0;
            for (int i = 0; i < SLOTS; i++) begin
                m_valid[k][i] = 1'b0;
                m_addr[k][i]  = '0;
                m_data[k][i]  = '0;
            end
        end
    endtask

    task automatic check_outputs(input int k);
        chk("slot_ok", slot_ok[k], m_ok(k));
        for (int i = 0; i < SLOTS; i++)
            if (m_valid[k][i]) chk("slot_dout", slot_dout[k][i*DW +: DW], m_data[k][i]);
    endtask

    task automatic serve(input int k, input int ad, input int rd, input bit same,
                         input logic [SLOTS-1:0] mid_cs, input bit mid_dl,
                         input logic [DW-1:0] d, output logic [AW-1:0] oa);
        int g;
        int n;
        logic [AW-1:0] lat;
        g = m_pick(k);
        n = 0;
        while (sdram_req[k] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_rise", sdram_req[k], 1);
        oa = sdram_addr[k];
        if (sdram_req[k] !== 1'b1) return;
        if (g >= 0) begin
            lat = a_of(k, g);
            chk("req_addr", sdram_addr[k], lat);
            m_ptr[k] = (g + 1) % SLOTS;
        end else begin
            lat = sdram_addr[k];
        end
        for (int j = 0; j < ad; j++) begin
            step();
            chk("req_hold", sdram_req[k], 1);
            chk("addr_hold", sdram_addr[k], lat);
        end
        sdram_ack[k] = 1'b1;
        if (same) begin
            data_rdy[k]  = 1'b1;
            data_read[k] = d;
        end
        step();
        sdram_ack[k] = 1'b0;
        data_rdy[k]  = 1'b0;
        chk("req_drop", sdram_req[k], 0);
        if (!same) begin
            slot_cs[k] = slot_cs[k] | mid_cs;
            if (mid_dl) begin
                downloading[k] = 1'b1;
                for (int i = 0; i < SLOTS; i++) m_valid[k][i] = 1'b0;
            end
            for (int j = 0; j < rd; j++) begin
                step();
                chk("req_wait_data", sdram_req[k], 0);
            end
            data_rdy[k]  = 1'b1;
            data_read[k] = d;
            step();
            data_rdy[k] = 1'b0;
        end
        if (g >= 0 && !downloading[k]) begin
            m_valid[k][g] = 1'b1;
            m_addr[k][g]  = lat;
            m_data[k][g]  = d;
        end
        check_outputs(k);
    endtask

    task automatic do_reset();
        slot_cs[0] = '0;
        slot_cs[1] = '0;
        rst_n = 1'b0;
        m_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] oa;
        int n;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            downloading[k] = 1'b0;
            slot_cs[k]     = '0;
            slot_addr[k]   = '0;
            sdram_ack[k]   = 1'b0;
            data_rdy[k]    = 1'b0;
            data_read[k]   = '0;
        end
        m_reset();
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            chk("rst_req", sdram_req[k], 0);
            chk("rst_addr", sdram_addr[k], 0);
            chk("rst_ok", slot_ok[k], 0);
            for (int i = 0; i < SLOTS; i++) chk("rst_dout", slot_dout[k][i*DW +: DW], 0);
        end
        rst_n = 1'b1;
        step();

        // Single request, one-cycle grant latency.
        set_addr(0, 0, 22'h012345);
        slot_cs[0] = 4'b0001;
        step();
        chk("t1_req_latency", sdram_req[0], 1);
        chk("t1_req_addr", sdram_addr[0], 22'h012345);
        serve(0, 2, 4, 1'b0, '0, 1'b0, 32'hDEADBEEF, oa);
        chk("t1_ok", slot_ok[0][0], 1);
        chk("t1_dout", slot_dout[0][31:0], 32'hDEADBEEF);

        // Cache hit and then a miss on the neighbouring word.
        for (int j = 0; j < 3; j++) begin
            step();
            chk("t2_hit_no_req", sdram_req[0], 0);
            chk("t2_hit_ok", slot_ok[0][0], 1);
        end
        set_addr(0, 0, 22'h012346);
        #1;
        chk("t2_miss_ok", slot_ok[0][0], 0);
        serve(0, 1, 2, 1'b0, '0, 1'b0, 32'h13579BDF, oa);
        chk("t2_new_req_addr", oa, 22'h012346);

        // Round-robin fairness and pointer wrap.
        do_reset();
        for (int i = 0; i < SLOTS; i++) set_addr(0, i, AW'(32'h100 * (i + 1)));
        slot_cs[0] = 4'b1111;
        for (int i = 0; i < SLOTS; i++) begin
            serve(0, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, '0, 1'b0, $urandom, oa);
            chk("t3_rr_order", oa, AW'(32'h100 * (i + 1)));
        end
        set_addr(0, 3, 22'h000444);
        set_addr(0, 1, 22'h000222);
        set_addr(0, 0, 22'h000111);
        serve(0, 1, 1, 1'b0, '0, 1'b0, $urandom, oa);
        chk("t3_wrap_0", oa, 22'h000111);
        serve(0, 1, 1, 1'b0, '0, 1'b0, $urandom, oa);
        chk("t3_wrap_1", oa, 22'h000222);
        serve(0, 1, 1, 1'b0, '0, 1'b0, $urandom, oa);
        chk("t3_wrap_3", oa, 22'h000444);

        // Fixed priority: slot 0 arrives while slot 1 waits for data.
        set_addr(1, 0, 22'h0000AA);
        set_addr(1, 1, 22'h000011);
        set_addr(1, 3, 22'h000033);
        slot_cs[1] = 4'b1010;
        serve(1, 1, 3, 1'b0, 4'b0001, 1'b0, 32'h11111111, oa);
        chk("t4_first", oa, 22'h000011);
        serve(1, 1, 1, 1'b0, '0, 1'b0, 32'h00000000, oa);
        chk("t4_second", oa, 22'h0000AA);
        serve(1, 0, 1, 1'b0, '0, 1'b0, 32'h33333333, oa);
        chk("t4_third", oa, 22'h000033);
        slot_cs[1] = '0;

        // Ack and data_rdy in the same cycle, next grant right after.
        set_addr(0, 2, 22'h002222);
        set_addr(0, 3, 22'h003333);
        serve(0, 1, 0, 1'b1, '0, 1'b0, 32'h0000CAFE, oa);
        chk("t5_addr", oa, 22'h002222);
        chk("t5_dout", slot_dout[0][2*DW +: DW], 32'h0000CAFE);
        chk("t5_ok", slot_ok[0][2], 1);
        step();
        chk("t5_next_req", sdram_req[0], 1);
        chk("t5_next_addr", sdram_addr[0], 22'h003333);
        serve(0, 0, 1, 1'b0, '0, 1'b0, $urandom, oa);

        // Download raised during WAIT_DATA.
        set_addr(0, 1, 22'h005555);
        serve(0, 1, 3, 1'b0, '0, 1'b1, 32'h77777777, oa);
        chk("t6_dl_ok", slot_ok[0], 0);
        for (int j = 0; j < 4; j++) begin
            step();
            chk("t6_dl_no_req", sdram_req[0], 0);
        end
        downloading[0] = 1'b0;
        n = 0;
        while (sdram_req[0] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("t6_req_after_dl", sdram_req[0], 1);
        chk("t6_req_after_dl_addr", sdram_addr[0], a_of(0, m_pick(0)));

        // Asynchronous reset in WAIT_ACK.
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("t6_rst_req", sdram_req[0], 0);
        chk("t6_rst_ok0", slot_ok[0], 0);
        chk("t6_rst_ok1", slot_ok[1], 0);
        step();
        rst_n = 1'b1;
        for (int j = 0; j < SLOTS && m_pick(0) >= 0; j++)
            serve(0, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, '0, 1'b0, $urandom, oa);

        // Randomized traffic on both policies.
        slot_cs[0] = '0;
        step();
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 40; t++) begin
                slot_cs[k] = SLOTS'($urandom_range(0, 15));
                for (int i = 0; i < SLOTS; i++)
                    if ($urandom_range(0, 1) == 1) set_addr(k, i, AW'($urandom_range(0, 3)));
                #1;
                check_outputs(k);
                if (m_pick(k) < 0) begin
                    for (int j = 0; j < 3; j++) begin
                        step();
                        chk("rnd_idle_no_req", sdram_req[k], 0);
                    end
                end else begin
                    serve(k, $urandom_range(0, 3), $urandom_range(0, 4),
                          ($urandom_range(0, 3) == 0), '0, 1'b0, $urandom, oa);
                end
            end
            slot_cs[k] = '0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
